// File: rtl/octal_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : octal_ram_pkg
//  Description : Shared types and constants for the Octal PSRAM MR bring-up.
//  Revision    : 1.0 - initial release
// ============================================================================
package octal_ram_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PWRUP   = 4'd1,
        ST_FETCH   = 4'd2,
        ST_ISSUE   = 4'd3,
        ST_WAIT_RD = 4'd4,
        ST_CHECK   = 4'd5,
        ST_NEXT    = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } state_t;

    localparam logic [7:0] c_MR0 = 8'h00;
    localparam logic [7:0] c_MR1 = 8'h01;
    localparam logic [7:0] c_MR2 = 8'h02;
    localparam logic [7:0] c_MR4 = 8'h04;
    localparam logic [7:0] c_MR8 = 8'h08;

    localparam int c_NUM_WR_DEF = 4;
    localparam int c_NUM_RD_DEF = 6;

endpackage
`default_nettype wire

// File: rtl/mr_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mr_wait_counter
//  Description : Loadable saturating down-counter with zero (terminal) flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mr_wait_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/octal_ram_mr_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : octal_ram_mr_init_seq
//  Description : Post-reset Octal PSRAM mode-register write/readback sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module octal_ram_mr_init_seq
    import octal_ram_pkg::*;
#(
    parameter int NUM_WR       = c_NUM_WR_DEF,
    parameter int NUM_RD       = c_NUM_RD_DEF,
    parameter int PWRUP_CYCLES = 20000,
    parameter int RD_TIMEOUT   = 255
) (
    input  logic       iClk,
    input  logic       iRst_N,
    input  logic       iStart,
    output logic [7:0] oCfgNo,
    input  logic [7:0] iCfgAddr,
    input  logic [7:0] iCfgData,
    output logic       oCmdValid,
    output logic       oCmdIsRead,
    output logic [7:0] oCmdAddr,
    output logic [7:0] oCmdData,
    input  logic       iCmdReady,
    input  logic       iRdValid,
    input  logic [7:0] iRdData,
    output logic       oBusy,
    output logic       oDone,
    output logic       oErr,
    output logic [7:0] oErrNo,
    output logic [7:0] oVendorId,
    output logic [7:0] oDeviceId
);

    localparam int              c_CNT_MAX  = (PWRUP_CYCLES > RD_TIMEOUT) ? PWRUP_CYCLES : RD_TIMEOUT;
    localparam int              c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_PWRUP_LD = c_CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RDTO_LD  = c_CNT_W'(RD_TIMEOUT - 1);
    localparam logic [7:0]      c_FIRST_RD = 8'(NUM_WR);
    localparam logic [7:0]      c_LAST_IDX = 8'(NUM_WR + NUM_RD - 1);

    state_t               r_state;
    logic                 r_pwrup_done;
    logic [7:0]           r_mr0;
    logic [7:0]           r_mr4;
    logic [7:0]           r_mr8;
    logic [7:0]           r_rd_data;

    logic                 w_is_rd;
    logic                 w_cnt_load;
    logic [c_CNT_W-1:0]   w_cnt_val;
    logic                 w_cnt_dec;
    logic                 w_cnt_zero;
    logic                 w_shadow_hit;
    logic [7:0]           w_shadow_val;

    assign w_is_rd = (oCfgNo >= c_FIRST_RD);

    // Loaded one cycle before the state it times, so PWRUP lasts exactly PWRUP_CYCLES.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = c_PWRUP_LD;
        if ((r_state == ST_IDLE) && iStart && !r_pwrup_done) begin
            w_cnt_load = 1'b1;
        end else if ((r_state == ST_ISSUE) && iCmdReady && oCmdIsRead) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = c_RDTO_LD;
        end
    end

    assign w_cnt_dec = (r_state == ST_PWRUP) || (r_state == ST_WAIT_RD);

    always_comb begin
        w_shadow_hit = 1'b1;
        w_shadow_val = 8'h00;
        case (oCmdAddr)
            c_MR0:   w_shadow_val = r_mr0;
            c_MR4:   w_shadow_val = r_mr4;
            c_MR8:   w_shadow_val = r_mr8;
            default: w_shadow_hit = 1'b0;
        endcase
    end

    mr_wait_counter #(
        .WIDTH (c_CNT_W)
    ) u_wait_cnt (
        .clk        (iClk),
        .rst_n      (iRst_N),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            r_state      <= ST_IDLE;
            r_pwrup_done <= 1'b0;
            r_mr0        <= 8'h00;
            r_mr4        <= 8'h00;
            r_mr8        <= 8'h00;
            r_rd_data    <= 8'h00;
            oCfgNo       <= 8'h00;
            oCmdValid    <= 1'b0;
            oCmdIsRead   <= 1'b0;
            oCmdAddr     <= 8'h00;
            oCmdData     <= 8'h00;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oErr         <= 1'b0;
            oErrNo       <= 8'h00;
            oVendorId    <= 8'h00;
            oDeviceId    <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iStart) begin
                        oDone   <= 1'b0;
                        oErr    <= 1'b0;
                        oErrNo  <= 8'h00;
                        oBusy   <= 1'b1;
                        oCfgNo  <= 8'h00;
                        r_state <= r_pwrup_done ? ST_FETCH : ST_PWRUP;
                    end
                end
                ST_PWRUP: begin
                    if (w_cnt_zero) begin
                        r_pwrup_done <= 1'b1;
                        r_state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    oCmdIsRead <= w_is_rd;
                    oCmdAddr   <= iCfgAddr;
                    oCmdData   <= w_is_rd ? 8'h00 : iCfgData;
                    oCmdValid  <= 1'b1;
                    r_state    <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (iCmdReady) begin
                        oCmdValid <= 1'b0;
                        if (oCmdIsRead) begin
                            r_state <= ST_WAIT_RD;
                        end else begin
                            case (oCmdAddr)
                                c_MR0:   r_mr0 <= oCmdData;
                                c_MR4:   r_mr4 <= oCmdData;
                                c_MR8:   r_mr8 <= oCmdData;
                                default: ;
                            endcase
                            r_state <= ST_NEXT;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    // A strobe on the terminal cycle still counts as in time.
                    if (iRdValid) begin
                        r_rd_data <= iRdData;
                        r_state   <= ST_CHECK;
                    end else if (w_cnt_zero) begin
                        oErr    <= 1'b1;
                        oErrNo  <= oCfgNo;
                        r_state <= ST_ERR;
                    end
                end
                ST_CHECK: begin
                    if (w_shadow_hit && (r_rd_data != w_shadow_val)) begin
                        oErr    <= 1'b1;
                        oErrNo  <= oCfgNo;
                        r_state <= ST_ERR;
                    end else begin
                        if (oCmdAddr == c_MR1) oVendorId <= r_rd_data;
                        if (oCmdAddr == c_MR2) oDeviceId <= r_rd_data;
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (oCfgNo == c_LAST_IDX) begin
                        oDone   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        oCfgNo  <= oCfgNo + 8'd1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_DONE, ST_ERR: begin
                    oBusy   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_octal_ram_mr_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_octal_ram_mr_init_seq
//  Description : Directed bench with MR table and echoing OPI engine model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_octal_ram_mr_init_seq;

    localparam int NUM_WR = 4;
    localparam int NUM_RD = 6;
    localparam int PWRUP  = 100;
    localparam int RDTO   = 255;

    logic       iClk;
    logic       iRst_N;
    logic       iStart;
    logic [7:0] oCfgNo;
    logic [7:0] iCfgAddr;
    logic [7:0] iCfgData;
    logic       oCmdValid;
    logic       oCmdIsRead;
    logic [7:0] oCmdAddr;
    logic [7:0] oCmdData;
    logic       iCmdReady;
    logic       iRdValid;
    logic [7:0] iRdData;
    logic       oBusy;
    logic       oDone;
    logic       oErr;
    logic [7:0] oErrNo;
    logic [7:0] oVendorId;
    logic [7:0] oDeviceId;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int start_cyc;
    int first_valid;
    int rd_acc_cyc;
    int no_rd_idx  = -1;
    int force_addr = -1;
    logic [7:0] force_val = 8'h00;
    int stall_idx  = -1;
    int stall_left = 0;
    int stall_ok   = 0;
    logic       pend;
    logic [7:0] pend_val;
    logic [7:0] mem [256];
    logic [7:0] log_addr [$];
    logic [7:0] log_data [$];
    logic [7:0] log_idx  [$];
    logic       log_rd   [$];

    octal_ram_mr_init_seq #(
        .NUM_WR       (NUM_WR),
        .NUM_RD       (NUM_RD),
        .PWRUP_CYCLES (PWRUP),
        .RD_TIMEOUT   (RDTO)
    ) dut (
        .iClk       (iClk),
        .iRst_N     (iRst_N),
        .iStart     (iStart),
        .oCfgNo     (oCfgNo),
        .iCfgAddr   (iCfgAddr),
        .iCfgData   (iCfgData),
        .oCmdValid  (oCmdValid),
        .oCmdIsRead (oCmdIsRead),
        .oCmdAddr   (oCmdAddr),
        .oCmdData   (oCmdData),
        .iCmdReady  (iCmdReady),
        .iRdValid   (iRdValid),
        .iRdData    (iRdData),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oErr       (oErr),
        .oErrNo     (oErrNo),
        .oVendorId  (oVendorId),
        .oDeviceId  (oDeviceId)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    initial begin
        forever begin
            @(posedge iClk);
            cyc++;
        end
    end

    // MR configuration table: 4 writes then 6 reads (read data field is junk on purpose)
    always_comb begin
        iCfgAddr = 8'hFF;
        iCfgData = 8'hFF;
        case (oCfgNo)
            8'd0: begin iCfgAddr = 8'h00; iCfgData = 8'h28; end
            8'd1: begin iCfgAddr = 8'h04; iCfgData = 8'h40; end
            8'd2: begin iCfgAddr = 8'h06; iCfgData = 8'hF0; end
            8'd3: begin iCfgAddr = 8'h08; iCfgData = 8'h00; end
            8'd4: begin iCfgAddr = 8'h00; iCfgData = 8'hAA; end
            8'd5: begin iCfgAddr = 8'h01; iCfgData = 8'hAA; end
            8'd6: begin iCfgAddr = 8'h02; iCfgData = 8'hAA; end
            8'd7: begin iCfgAddr = 8'h03; iCfgData = 8'hAA; end
            8'd8: begin iCfgAddr = 8'h04; iCfgData = 8'hAA; end
            8'd9: begin iCfgAddr = 8'h08; iCfgData = 8'hAA; end
            default: ;
        endcase
    end

    // OPI engine model: logs accepted commands, echoes MR contents one cycle later
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[1] = 8'h0D;
        mem[2] = 8'h93;
        mem[3] = 8'h11;
        iCmdReady   = 1'b1;
        iRdValid    = 1'b0;
        iRdData     = 8'h00;
        pend        = 1'b0;
        pend_val    = 8'h00;
        first_valid = -1;
        rd_acc_cyc  = 0;
        forever begin
            @(negedge iClk);
            iRdValid = 1'b0;
            if (!iRst_N) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    iRdValid = 1'b1;
                    iRdData  = pend_val;
                    pend     = 1'b0;
                end
                if (oCmdValid && first_valid < 0) first_valid = cyc;
                iCmdReady = 1'b1;
                if (oCmdValid && int'(oCfgNo) == stall_idx && stall_left > 0) begin
                    iCmdReady = 1'b0;
                    stall_left--;
                    if (oCmdAddr == 8'h06 && oCmdData == 8'hF0 && !oCmdIsRead) stall_ok++;
                end
                if (oCmdValid && iCmdReady) begin
                    log_addr.push_back(oCmdAddr);
                    log_data.push_back(oCmdData);
                    log_idx.push_back(oCfgNo);
                    log_rd.push_back(oCmdIsRead);
                    if (!oCmdIsRead) begin
                        mem[oCmdAddr] = oCmdData;
                    end else begin
                        rd_acc_cyc = cyc;
                        if (int'(oCfgNo) != no_rd_idx) begin
                            pend     = 1'b1;
                            pend_val = (int'(oCmdAddr) == force_addr) ? force_val : mem[oCmdAddr];
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int count_idx(input int idx);
        int n = 0;
        foreach (log_idx[i]) if (int'(log_idx[i]) == idx) n++;
        return n;
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_idx.delete();
        log_rd.delete();
        first_valid = -1;
    endtask

    task automatic start_seq();
        @(negedge iClk);
        iStart    = 1'b1;
        start_cyc = cyc;
        @(negedge iClk);
        iStart    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 5000; i++) begin
            if (!oBusy) break;
            @(negedge iClk);
        end
        checks++;
        if (oBusy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: oBusy=%b required 0", name, oBusy);
        end
    endtask

    task automatic test_reset();
        iRst_N = 1'b0;
        iStart = 1'b0;
        repeat (3) @(negedge iClk);
        checks++;
        if ({oBusy, oDone, oErr, oCmdValid, oCmdIsRead} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000", {oBusy, oDone, oErr, oCmdValid, oCmdIsRead});
        end
        checks++;
        if ({oCfgNo, oErrNo} !== 16'h0) begin
            errors++;
            $display("FAIL reset_idx: got %h required 0000", {oCfgNo, oErrNo});
        end
        checks++;
        if ({oCmdAddr, oCmdData, oVendorId, oDeviceId} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 00000000", {oCmdAddr, oCmdData, oVendorId, oDeviceId});
        end
        iRst_N = 1'b1;
    endtask

    task automatic test_full_seq();
        logic [7:0] exp_wa [4] = '{8'h00, 8'h04, 8'h06, 8'h08};
        logic [7:0] exp_wd [4] = '{8'h28, 8'h40, 8'hF0, 8'h00};
        logic [7:0] exp_ra [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h08};
        clear_log();
        start_seq();
        wait_idle("full");
        checks++;
        if (first_valid - start_cyc !== PWRUP + 2) begin
            errors++;
            $display("FAIL full_pwrup_latency: got %0d required %0d", first_valid - start_cyc, PWRUP + 2);
        end
        checks++;
        if (log_addr.size() !== 10) begin
            errors++;
            $display("FAIL full_cmd_count: got %0d required 10", log_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({log_rd[i], log_addr[i], log_data[i]} !== {1'b0, exp_wa[i], exp_wd[i]}) begin
                errors++;
                $display("FAIL full_write%0d: got rd=%b %h/%h required rd=0 %h/%h",
                         i, log_rd[i], log_addr[i], log_data[i], exp_wa[i], exp_wd[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({log_rd[4+i], log_addr[4+i], log_data[4+i]} !== {1'b1, exp_ra[i], 8'h00}) begin
                errors++;
                $display("FAIL full_read%0d: got rd=%b %h/%h required rd=1 %h/00",
                         i, log_rd[4+i], log_addr[4+i], log_data[4+i], exp_ra[i]);
            end
        end
        checks++;
        if ({oDone, oErr} !== 2'b10) begin
            errors++;
            $display("FAIL full_flags: got done/err=%b required 10", {oDone, oErr});
        end
        checks++;
        if ({oVendorId, oDeviceId} !== 16'h0D93) begin
            errors++;
            $display("FAIL full_ids: got %h required 0d93", {oVendorId, oDeviceId});
        end
    endtask

    task automatic test_mismatch();
        force_addr = 4;
        force_val  = 8'h47;
        clear_log();
        start_seq();
        wait_idle("mismatch");
        force_addr = -1;
        checks++;
        if ({oDone, oErr} !== 2'b01) begin
            errors++;
            $display("FAIL mismatch_flags: got done/err=%b required 01", {oDone, oErr});
        end
        checks++;
        if (oErrNo !== 8'd8) begin
            errors++;
            $display("FAIL mismatch_errno: got %0d required 8", oErrNo);
        end
        checks++;
        if (count_idx(9) !== 0 || log_addr.size() !== 9) begin
            errors++;
            $display("FAIL mismatch_no_idx9: got idx9=%0d total=%0d required 0 and 9", count_idx(9), log_addr.size());
        end
    endtask

    task automatic test_timeout();
        int err_cyc = -1;
        no_rd_idx = 5;
        clear_log();
        start_seq();
        for (int i = 0; i < 1000; i++) begin
            if (oErr) begin
                err_cyc = cyc;
                break;
            end
            @(negedge iClk);
        end
        checks++;
        if (oErr !== 1'b1 || oErrNo !== 8'd5) begin
            errors++;
            $display("FAIL timeout_err: got err=%b errno=%0d required 1 and 5", oErr, oErrNo);
        end
        checks++;
        if (err_cyc - rd_acc_cyc !== RDTO + 1) begin
            errors++;
            $display("FAIL timeout_len: got %0d required %0d", err_cyc - rd_acc_cyc, RDTO + 1);
        end
        wait_idle("timeout");
        no_rd_idx = -1;
        checks++;
        if ({oDone, oErr} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_flags: got done/err=%b required 01", {oDone, oErr});
        end
    endtask

    task automatic test_backpressure();
        stall_idx  = 2;
        stall_left = 10;
        stall_ok   = 0;
        clear_log();
        start_seq();
        wait_idle("stall");
        stall_idx = -1;
        checks++;
        if (stall_ok !== 10) begin
            errors++;
            $display("FAIL stall_stable: got %0d stable cycles required 10", stall_ok);
        end
        checks++;
        if (count_idx(2) !== 1) begin
            errors++;
            $display("FAIL stall_single_accept: got %0d required 1", count_idx(2));
        end
        checks++;
        if ({oDone, oErr} !== 2'b10 || log_addr.size() !== 10) begin
            errors++;
            $display("FAIL stall_done: got done/err=%b cmds=%0d required 10 and 10", {oDone, oErr}, log_addr.size());
        end
    endtask

    task automatic test_restart();
        clear_log();
        start_seq();
        checks++;
        if ({oBusy, oDone} !== 2'b10) begin
            errors++;
            $display("FAIL restart_cleared: got busy/done=%b required 10", {oBusy, oDone});
        end
        repeat (4) @(negedge iClk);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        wait_idle("restart");
        checks++;
        if (first_valid - start_cyc !== 2) begin
            errors++;
            $display("FAIL restart_latency: got %0d required 2", first_valid - start_cyc);
        end
        checks++;
        if ({oDone, oErr} !== 2'b10 || log_addr.size() !== 10) begin
            errors++;
            $display("FAIL restart_done: got done/err=%b cmds=%0d required 10 and 10", {oDone, oErr}, log_addr.size());
        end
    endtask

    task automatic test_reset_midop();
        no_rd_idx = 4;
        clear_log();
        start_seq();
        for (int i = 0; i < 2000; i++) begin
            if (log_addr.size() >= 5) break;
            @(negedge iClk);
        end
        repeat (3) @(negedge iClk);
        #2;
        iRst_N = 1'b0;
        #1;
        checks++;
        if ({oBusy, oDone, oErr, oCmdValid, oCmdIsRead, oCfgNo} !== 13'h0) begin
            errors++;
            $display("FAIL midop_reset_ctrl: got %h required 0000", {oBusy, oDone, oErr, oCmdValid, oCmdIsRead, oCfgNo});
        end
        checks++;
        if ({oCmdAddr, oCmdData, oVendorId, oDeviceId, oErrNo} !== 40'h0) begin
            errors++;
            $display("FAIL midop_reset_data: got %h required 0", {oCmdAddr, oCmdData, oVendorId, oDeviceId, oErrNo});
        end
        @(negedge iClk);
        iRst_N    = 1'b1;
        no_rd_idx = -1;
        clear_log();
        start_seq();
        wait_idle("midop");
        checks++;
        if (first_valid - start_cyc !== PWRUP + 2) begin
            errors++;
            $display("FAIL midop_pwrup_again: got %0d required %0d", first_valid - start_cyc, PWRUP + 2);
        end
        checks++;
        if ({oDone, oErr, oVendorId, oDeviceId} !== {2'b10, 16'h0D93}) begin
            errors++;
            $display("FAIL midop_done: got %b %h required 10 0d93", {oDone, oErr}, {oVendorId, oDeviceId});
        end
    endtask

    initial begin
        iRst_N = 1'b0;
        iStart = 1'b0;
        test_reset();
        test_full_seq();
        test_mismatch();
        test_timeout();
        test_backpressure();
        test_restart();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
